ex_alu_muldiv: RTL and testbench
================================

Name: ex_alu_muldiv

Overview:
- EX-stage consumer of the ID/EX pipeline register outputs: selects operands, runs the single-cycle ALU, and runs an iterative unsigned multiply/divide unit.
- Produces the EX result for the EX/MEM register.
- Drives ex_stall back to the ID/EX register and the earlier stages while a multi-cycle op is in flight. While ex_stall is high, those stages hold their contents; they do not flush.

Parameters:
- XLEN, 32, datapath width.
- MD_ITERS, 32, iterations per multiply/divide; must equal XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  kill the in-flight EX instruction (synchronous)
- alu_src1  input  2  operand A select: 00 rs1_data, 01 pc, 10/11 zero
- alu_src2  input  2  operand B select: 00 rs2_data, 01 imm, 10/11 constant 4
- alu_op  input  3  ALU function
- alu_op_chosen  input  1  alternate-function modifier
- md_valid  input  1  EX instruction is a mul/div op (overrides ALU result)
- md_op  input  2  00 MUL (low), 01 MULHU (high unsigned), 10 DIVU, 11 REMU
- rs1_data  input  32  source 1 value from ID/EX
- rs2_data  input  32  source 2 value from ID/EX
- pc  input  32  instruction PC
- imm  input  32  immediate
- result  output  32  EX result toward EX/MEM
- store_data  output  32  rs2_data passed through, combinational
- ex_stall  output  1  hold ID/EX and upstream stages
- md_busy  output  1  state is RUN (debug/perf counter)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- On reset:
  - state = IDLE, iteration counter = 0, all md datapath registers = 0.
  - result = 0, ex_stall = 0, md_busy = 0.
- Operand A/B: combinational muxes per alu_src1/alu_src2.
- ALU, combinational, with alu_op_chosen = 0:
  - 000 add, 001 sll (B[4:0]), 010 slt (signed), 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
- ALU with alu_op_chosen = 1:
  - 000 sub, 101 sra.
  - All other codes behave as their chosen = 0 function.
- All arithmetic is modulo 2^32; no overflow flag.
- md_valid = 0: result = ALU output, same cycle; ex_stall = 0.
- Multiply/divide FSM states: IDLE, RUN, DONE.
- IDLE:
  - If md_valid & ~flush: latch A, B and md_op; clear counter; go to RUN. ex_stall = 1 combinationally in this cycle.
  - Otherwise remain in IDLE.
- RUN:
  - ex_stall = 1, md_busy = 1.
  - One iteration per cycle. MUL/MULHU: shift-add into a 64-bit product. DIVU/REMU: restoring, 1 quotient bit per cycle.
  - When counter = MD_ITERS-1, go to DONE.
- DONE:
  - ex_stall = 0.
  - result = selected md result: product[31:0], product[63:32], quotient, or remainder.
  - md_valid is ignored (same instruction still present); go to IDLE unconditionally.
- Latency: fixed 1 + MD_ITERS + 1 cycles. ex_stall is high for exactly MD_ITERS+1 cycles; result is valid in the DONE cycle.
- Back-to-back md ops: a new md instruction appears the cycle after DONE and is accepted from IDLE. There is no dead cycle beyond DONE.
- Divide by zero takes the same latency:
  - DIVU → 0xFFFFFFFF.
  - REMU → dividend.
- Result selection uses the latched md_op and operands. Inputs changing during RUN have no effect.
- flush: in any state, next state = IDLE and the counter clears. ex_stall is forced 0 in the flush cycle. No md result is produced.
- rst mid-operation: identical to flush, plus all registers are cleared.
- flush and md_valid in the same IDLE cycle: the op is not started.

Test Plan:
1. add: src1 = 00 rs1 = 0x7FFFFFFF, src2 = 01 imm = 1, op 000, chosen 0 -> result 0x80000000 in the same cycle; ex_stall stays 0.
2. sra and pc+4: src2 = 00, chosen 1, op 101, rs1 = 0x80000000, rs2 = 4 -> 0xF8000000. Then src1 = 01 pc = 0x100, src2 = 10, op 000 -> 0x104.
3. MUL and MULHU: A = B = 0x00010000. MUL -> 0x00000000; MULHU -> 0x00000001. ex_stall is high exactly 33 cycles, and the result appears on the following DONE cycle.
4. DIVU/REMU: 100 / 7 -> 14 and 2. 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF and 0xF. Divide by zero with dividend 5 -> DIVU 0xFFFFFFFF, REMU 5.
5. Flush: pulse flush at RUN cycle 10 -> IDLE next cycle, ex_stall 0, md_busy 0. A subsequent MUL of 3 × 5 returns 15 with full latency.
6. Back-to-back: DIVU 9/3 immediately followed by MUL 6 × 7 -> 3, then 42. The second op starts the cycle after the first DONE. Also assert rst mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_alu_muldiv.sv
// ex_alu_muldiv: EX stage operand select, single-cycle ALU and iterative unsigned mul/div
// Ports: clk/rst (sync, active-high), flush; alu_src1/alu_src2/alu_op/alu_op_chosen pick operands and
// ALU function; md_valid/md_op launch MUL/MULHU/DIVU/REMU; rs1_data/rs2_data/pc/imm operands;
// result toward EX/MEM, store_data = rs2_data, ex_stall holds upstream stages, md_busy marks RUN.
module ex_alu_muldiv #(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [1:0]      alu_src1,
  input  logic [1:0]      alu_src2,
  input  logic [2:0]      alu_op,
  input  logic            alu_op_chosen,
  input  logic            md_valid,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] store_data,
  output logic            ex_stall,
  output logic            md_busy
);
  localparam int CW = $clog2(MD_ITERS);
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [XLEN-1:0] op_a, op_b, alu_y, sra_y;
  logic [SW-1:0] shamt;
  logic [1:0] state_q, state_d, op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [2*XLEN-1:0] p_q, p_d, mul_step, div_step;
  logic [XLEN:0] msum, dr, dsub;
  assign op_a  = alu_src1 == 2'b00 ? rs1_data : alu_src1 == 2'b01 ? pc : '0;
  assign op_b  = alu_src2 == 2'b00 ? rs2_data : alu_src2 == 2'b01 ? imm : XLEN'(4);
  assign shamt = op_b[SW-1:0];
  assign sra_y = $signed(op_a) >>> shamt;
  always_comb begin
    alu_y = op_a + op_b;
    case (alu_op)
      3'b000: alu_y = alu_op_chosen ? op_a - op_b : op_a + op_b;
      3'b001: alu_y = op_a << shamt;
      3'b010: alu_y = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'b011: alu_y = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'b100: alu_y = op_a ^ op_b;
      3'b101: alu_y = alu_op_chosen ? sra_y : op_a >> shamt;
      3'b110: alu_y = op_a | op_b;
      3'b111: alu_y = op_a & op_b;
    endcase
  end
  // p_q holds {hi, lo}: product accumulator for multiply, {remainder, dividend/quotient} for divide
  assign msum     = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {msum, p_q[XLEN-1:1]};
  assign dr       = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign dsub     = dr - {1'b0, m_q};
  assign div_step = dsub[XLEN] ? {dr[XLEN-1:0], p_q[XLEN-2:0], 1'b0} : {dsub[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    m_d     = m_q;
    p_d     = p_q;
    if (state_q == IDLE && md_valid) begin
      state_d = RUN;
      cnt_d   = '0;
      op_d    = md_op;
      m_d     = md_op[1] ? op_b : op_a;
      p_d     = {{XLEN{1'b0}}, md_op[1] ? op_a : op_b};
    end else if (state_q == RUN) begin
      p_d     = op_q[1] ? div_step : mul_step;
      cnt_d   = cnt_q + CW'(1);
      state_d = cnt_q == CW'(MD_ITERS-1) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      m_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      m_q     <= m_d;
      p_q     <= p_d;
    end
  end
  assign md_busy    = state_q == RUN;
  assign ex_stall   = ~rst & ~flush & ((state_q == IDLE & md_valid) | md_busy);
  assign store_data = rs2_data;
  assign result     = rst ? '0 : (state_q == DONE & ~flush) ? (op_q[0] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0]) : alu_y;
endmodule

// File: tb/tb_ex_alu_muldiv.sv
// tb_ex_alu_muldiv: directed self-checking bench for ex_alu_muldiv
module tb_ex_alu_muldiv;
  logic clk = 0, rst, flush, alu_op_chosen, md_valid, ex_stall, md_busy;
  logic [1:0] alu_src1, alu_src2, md_op;
  logic [2:0] alu_op;
  logic [31:0] rs1_data, rs2_data, pc, imm, result, store_data;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [1:0] s1, s2;
    logic [2:0] op;
    logic ch;
    logic [31:0] a, b, exp;
  } alu_vec_t;
  always #5 clk = ~clk;
  ex_alu_muldiv dut (
    .clk(clk), .rst(rst), .flush(flush), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_op(alu_op), .alu_op_chosen(alu_op_chosen), .md_valid(md_valid), .md_op(md_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm), .result(result),
    .store_data(store_data), .ex_stall(ex_stall), .md_busy(md_busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int stalls);
    alu_src1 = 2'b00; alu_src2 = 2'b00; alu_op = 3'b000; alu_op_chosen = 0;
    md_op = op; rs1_data = a; rs2_data = b; md_valid = 1; stalls = 0;
    #1;
    while (ex_stall && stalls < 100) begin
      stalls++;
      step();
      rs1_data = $urandom;
      rs2_data = $urandom;
      #1;
    end
    res = result;
    step();
    md_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1; flush = 0; alu_src1 = 0; alu_src2 = 0; alu_op = 0; alu_op_chosen = 0;
    md_valid = 0; md_op = 0; rs1_data = 0; rs2_data = 0; pc = 0; imm = 0;
    step(); step();
    n_chk++;
    if (result !== 0 || ex_stall !== 0 || md_busy !== 0) begin
      n_fail++; $display("FAIL reset_hold: result=%h stall=%b busy=%b want 0/0/0", result, ex_stall, md_busy);
    end
    rst = 0;
    step();
    n_chk++;
    if (result !== 0 || ex_stall !== 0 || md_busy !== 0) begin
      n_fail++; $display("FAIL reset_release: result=%h stall=%b busy=%b want 0/0/0", result, ex_stall, md_busy);
    end
  endtask
  task automatic test_alu();
    alu_vec_t v [12];
    v[0]  = '{2'b00, 2'b01, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    v[1]  = '{2'b00, 2'b00, 3'b101, 1'b1, 32'h80000000, 32'h00000004, 32'hF8000000};
    v[2]  = '{2'b01, 2'b10, 3'b000, 1'b0, 32'h00000100, 32'h00000000, 32'h00000104};
    v[3]  = '{2'b00, 2'b00, 3'b000, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    v[4]  = '{2'b00, 2'b00, 3'b001, 1'b0, 32'h00000001, 32'h00000023, 32'h00000008};
    v[5]  = '{2'b00, 2'b00, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    v[6]  = '{2'b00, 2'b00, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    v[7]  = '{2'b00, 2'b00, 3'b100, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    v[8]  = '{2'b00, 2'b00, 3'b101, 1'b0, 32'h80000000, 32'h00000004, 32'h08000000};
    v[9]  = '{2'b00, 2'b00, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
    v[10] = '{2'b00, 2'b00, 3'b111, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    v[11] = '{2'b10, 2'b11, 3'b000, 1'b0, 32'h00000123, 32'h00000456, 32'h00000004};
    for (int i = 0; i < 12; i++) begin
      alu_src1 = v[i].s1; alu_src2 = v[i].s2; alu_op = v[i].op; alu_op_chosen = v[i].ch;
      rs1_data = v[i].a; pc = v[i].a; rs2_data = v[i].b; imm = v[i].b; md_valid = 0;
      #1;
      n_chk++;
      if (result !== v[i].exp || ex_stall !== 0 || store_data !== v[i].b) begin
        n_fail++;
        $display("FAIL alu_vec%0d: result=%h stall=%b store=%h want %h/0/%h", i, result, ex_stall, store_data, v[i].exp, v[i].b);
      end
      step();
    end
  endtask
  task automatic test_mul();
    logic [31:0] r;
    int s;
    do_md(2'b00, 32'h00010000, 32'h00010000, r, s);
    n_chk++;
    if (r !== 32'h0 || s !== 33) begin n_fail++; $display("FAIL mul_low: result=%h stall_cycles=%0d want 00000000/33", r, s); end
    do_md(2'b01, 32'h00010000, 32'h00010000, r, s);
    n_chk++;
    if (r !== 32'h1 || s !== 33) begin n_fail++; $display("FAIL mulhu: result=%h stall_cycles=%0d want 00000001/33", r, s); end
    do_md(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, r, s);
    n_chk++;
    if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_max: result=%h want FFFFFFFE", r); end
    do_md(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, r, s);
    n_chk++;
    if (r !== 32'h1) begin n_fail++; $display("FAIL mul_max: result=%h want 00000001", r); end
  endtask
  task automatic test_div();
    logic [31:0] r;
    int s;
    do_md(2'b10, 32'd100, 32'd7, r, s);
    n_chk++;
    if (r !== 32'd14 || s !== 33) begin n_fail++; $display("FAIL divu_100_7: result=%h stall_cycles=%0d want 0000000e/33", r, s); end
    do_md(2'b11, 32'd100, 32'd7, r, s);
    n_chk++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7: result=%h want 00000002", r); end
    do_md(2'b10, 32'hFFFFFFFF, 32'h10, r, s);
    n_chk++;
    if (r !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL divu_max: result=%h want 0fffffff", r); end
    do_md(2'b11, 32'hFFFFFFFF, 32'h10, r, s);
    n_chk++;
    if (r !== 32'hF) begin n_fail++; $display("FAIL remu_max: result=%h want 0000000f", r); end
    do_md(2'b10, 32'd5, 32'd0, r, s);
    n_chk++;
    if (r !== 32'hFFFFFFFF || s !== 33) begin n_fail++; $display("FAIL divu_by0: result=%h stall_cycles=%0d want ffffffff/33", r, s); end
    do_md(2'b11, 32'd5, 32'd0, r, s);
    n_chk++;
    if (r !== 32'd5) begin n_fail++; $display("FAIL remu_by0: result=%h want 00000005", r); end
  endtask
  task automatic test_flush();
    logic [31:0] r;
    int s;
    alu_src1 = 0; alu_src2 = 0; alu_op = 0; alu_op_chosen = 0;
    rs1_data = 3; rs2_data = 5; md_op = 2'b00; md_valid = 1;
    #1;
    n_chk++;
    if (ex_stall !== 1) begin n_fail++; $display("FAIL accept_stall: stall=%b want 1", ex_stall); end
    for (int i = 0; i < 10; i++) step();
    flush = 1;
    #1;
    n_chk++;
    if (ex_stall !== 0 || md_busy !== 1) begin n_fail++; $display("FAIL flush_cycle: stall=%b busy=%b want 0/1", ex_stall, md_busy); end
    step();
    flush = 0; md_valid = 0;
    #1;
    n_chk++;
    if (ex_stall !== 0 || md_busy !== 0 || result !== 32'd8) begin
      n_fail++; $display("FAIL after_flush: stall=%b busy=%b result=%h want 0/0/00000008", ex_stall, md_busy, result);
    end
    do_md(2'b00, 32'd3, 32'd5, r, s);
    n_chk++;
    if (r !== 32'd15 || s !== 33) begin n_fail++; $display("FAIL mul_after_flush: result=%h stall_cycles=%0d want 0000000f/33", r, s); end
    md_valid = 1; flush = 1; md_op = 2'b00; rs1_data = 3; rs2_data = 5;
    #1;
    n_chk++;
    if (ex_stall !== 0) begin n_fail++; $display("FAIL flush_idle_stall: stall=%b want 0", ex_stall); end
    step();
    flush = 0; md_valid = 0;
    #1;
    n_chk++;
    if (md_busy !== 0) begin n_fail++; $display("FAIL flush_idle_start: busy=%b want 0", md_busy); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int s1, s2;
    do_md(2'b10, 32'd9, 32'd3, r1, s1);
    do_md(2'b00, 32'd6, 32'd7, r2, s2);
    n_chk++;
    if (r1 !== 32'd3 || s1 !== 33) begin n_fail++; $display("FAIL b2b_divu: result=%h stall_cycles=%0d want 00000003/33", r1, s1); end
    n_chk++;
    if (r2 !== 32'd42 || s2 !== 33) begin n_fail++; $display("FAIL b2b_mul: result=%h stall_cycles=%0d want 0000002a/33", r2, s2); end
  endtask
  task automatic test_reset_mid_run();
    logic [31:0] r;
    int s;
    alu_src1 = 0; alu_src2 = 0; rs1_data = 9; rs2_data = 3; md_op = 2'b10; md_valid = 1;
    for (int i = 0; i < 6; i++) step();
    n_chk++;
    if (md_busy !== 1) begin n_fail++; $display("FAIL run_busy: busy=%b want 1", md_busy); end
    rst = 1;
    step();
    n_chk++;
    if (result !== 0 || ex_stall !== 0 || md_busy !== 0) begin
      n_fail++; $display("FAIL rst_mid_run: result=%h stall=%b busy=%b want 0/0/0", result, ex_stall, md_busy);
    end
    rst = 0; md_valid = 0;
    step();
    n_chk++;
    if (ex_stall !== 0 || md_busy !== 0) begin n_fail++; $display("FAIL after_rst: stall=%b busy=%b want 0/0", ex_stall, md_busy); end
    do_md(2'b00, 32'd2, 32'd3, r, s);
    n_chk++;
    if (r !== 32'd6 || s !== 33) begin n_fail++; $display("FAIL mul_after_rst: result=%h stall_cycles=%0d want 00000006/33", r, s); end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
